// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the parametrised FIFO
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATA_W simple dual-port RAM, sync write, async read
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised single-clock FIFO with thresholds, sticky errors and FWFT option
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = FIFO_MODE_STD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   rd,
    input  logic                   clr_err,
    output logic [DATA_W-1:0]      data_out,
    output logic                   rd_valid,
    output logic                   ffull,
    output logic                   fempty,
    output logic                   falmost_full,
    output logic                   falmost_empty,
    output logic                   foverflow,
    output logic                   funderflow,
    output logic [clog2(DEPTH):0]  count
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("param_fifo: DEPTH must be a power of 2 and >= 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("param_fifo: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("param_fifo: AE_THRESH out of range 0..DEPTH-1");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("param_fifo: FWFT must be 0 or 1");
    end

    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              rd_ok, wr_ok;
    logic [DATA_W-1:0] ram_rdata;

    assign fempty        = (count_q == '0);
    assign ffull         = (count_q == CW'(DEPTH));
    assign falmost_full  = (count_q >= CW'(AF_THRESH));
    assign falmost_empty = (count_q <= CW'(AE_THRESH));
    assign foverflow     = ovf_q;
    assign funderflow    = udf_q;
    assign count         = count_q;

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign rd_ok = rd & ~fempty;
    assign wr_ok = wr & (~ffull | rd_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_ok) wptr_d = wptr_q + AW'(1);
        if (rd_ok) rptr_d = rptr_q + AW'(1);
        if (wr_ok && !rd_ok)      count_d = count_q + CW'(1);
        else if (rd_ok && !wr_ok) count_d = count_q - CW'(1);
        ovf_d = (ovf_q & ~clr_err) | (wr & ~wr_ok);
        udf_d = (udf_q & ~clr_err) | (rd & ~rd_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_ok & rst_n),
        .waddr_i (wptr_q),
        .wdata_i (data_in),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is masked while empty so stale RAM contents never show.
        assign data_out = fempty ? '0 : ram_rdata;
        assign rd_valid = ~fempty;
    end else begin : g_std
        logic [DATA_W-1:0] dout_q;
        logic              rvalid_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dout_q   <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_ok;
                if (rd_ok) dout_q <= ram_rdata;
            end
        end

        assign data_out = dout_q;
        assign rd_valid = rvalid_q;
    end

endmodule
